// File: rtl/sd_dac_pkg.sv
// Shared definitions for the sigma-delta DAC sample scheduler.
// Holds the scheduler state encodings, statistics counter width and default sample width.
package sd_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } sd_state_t;

    localparam int CNT_W      = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/sd_dac_sync_fifo.sv
// Small synchronous sample FIFO with show-ahead head output.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module sd_dac_sync_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Sample storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sd_dac_sample_scheduler.sv
// Sigma-delta DAC interpolating-filter sequencer.
// Buffers upstream samples, primes the FIFO, then pulses filt_ce every CE_DIV clocks and
// loads a new sample into filt_data every INTERP_L pulses, counting underruns.
// Optional feature macro: SD_DAC_HOLD_LAST_EN -- when defined, an underrun repeats the last
// popped sample instead of presenting zero.
module sd_dac_sample_scheduler
    import sd_dac_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int FIFO_DEPTH = 8,
    parameter  int CE_DIV     = 4,
    parameter  int INTERP_L   = 2,
    parameter  int PRIME_LVL  = 2,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              clr_stat,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              filt_ce,
    output logic [DATA_W-1:0] filt_data,
    output logic              sample_strobe,
    output logic [1:0]        state,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int DIV_W = $clog2(CE_DIV);
    localparam int PH_W  = (INTERP_L > 1) ? $clog2(INTERP_L) : 1;

    sd_state_t         state_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] hold_value;
    logic              fifo_full;
    logic              fifo_empty;
    logic              active;
    logic              tick;
    logic              last_phase;
    logic              load_tick;
    logic              level_ok;
    logic              fifo_pop;
    logic              underrun_evt;

    assign active       = (state_q == ST_RUN) || (state_q == ST_UNDERRUN);
    assign tick         = active && (div_cnt == DIV_W'(CE_DIV - 1));
    assign last_phase   = (ph_cnt == PH_W'(INTERP_L - 1));
    assign load_tick    = tick && (ph_cnt == '0);
    assign level_ok     = (fifo_level >= LVL_W'(PRIME_LVL));
    assign fifo_pop     = run_en && load_tick && !fifo_empty;
    assign underrun_evt = run_en && load_tick && fifo_empty;
    assign s_ready      = !fifo_full;
    assign state        = state_q;

    sd_dac_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef SD_DAC_HOLD_LAST_EN
    logic [DATA_W-1:0] last_sample;

    // Remember the most recently popped sample so an underrun can repeat it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sample <= '0;
        end else if (fifo_pop) begin
            last_sample <= fifo_head;
        end
    end

    assign hold_value = last_sample;
`else
    assign hold_value = '0;
`endif

    // Scheduler FSM with CE divider, phase counter and registered filter-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_cnt       <= '0;
            ph_cnt        <= '0;
            filt_ce       <= 1'b0;
            sample_strobe <= 1'b0;
            filt_data     <= '0;
        end else begin
            filt_ce       <= 1'b0;
            sample_strobe <= 1'b0;
            if (!run_en) begin
                state_q   <= ST_IDLE;
                div_cnt   <= '0;
                ph_cnt    <= '0;
                filt_data <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_PRIME;
                        div_cnt <= '0;
                        ph_cnt  <= '0;
                    end
                    ST_PRIME: begin
                        div_cnt <= '0;
                        ph_cnt  <= '0;
                        if (level_ok) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN, ST_UNDERRUN: begin
                        if (tick) begin
                            div_cnt <= '0;
                            filt_ce <= 1'b1;
                            ph_cnt  <= last_phase ? '0 : ph_cnt + PH_W'(1);
                            if (load_tick) begin
                                sample_strobe <= 1'b1;
                                if (fifo_empty) begin
                                    filt_data <= hold_value;
                                    state_q   <= ST_UNDERRUN;
                                end else begin
                                    filt_data <= fifo_head;
                                    if ((state_q == ST_UNDERRUN) && level_ok) begin
                                        state_q <= ST_RUN;
                                    end
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating underrun statistic; a clear wins over a coincident underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (clr_stat) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && (underrun_cnt != CNT_MAX)) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end else begin
            underrun_cnt <= underrun_cnt;
        end
    end

endmodule
